// File: rtl/lif_neuron_core.sv
// Time-multiplexed bank of N leaky integrate-and-fire neurons. A prescaler tick
// starts a sweep that updates one neuron per clock, then publishes the spike vector.
module lif_neuron_core #(
  parameter int N          = 8,
  parameter int VW         = 16,
  parameter int WEIGHT     = 1024,
  parameter int THRESH     = 8192,
  parameter int LEAK_SHIFT = 4,
  parameter int REFRAC     = 2,
  parameter int TICK_DIV   = 120
) (
  input  logic         iCLK,
  input  logic         iRESETn,
  input  logic         iENABLE,
  input  logic [N-1:0] iSPIKE_IN,
  output logic [N-1:0] oSPIKE,
  output logic         oSPIKE_VALID,
  output logic         oBUSY,
  output logic         oSAT,
  output logic         oMISSED
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);
  localparam logic [VW:0]   WEIGHT_X  = (VW+1)'(WEIGHT);
  localparam logic [VW-1:0] THRESH_V  = VW'(THRESH);
  localparam logic [3:0]    REFRAC_V  = 4'(REFRAC);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_PUBLISH} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N-1:0]  rin_q, rin_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [N-1:0]  spike_q, spike_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          sat_q, sat_d;
  logic          missed_q, missed_d;
  logic [VW-1:0] v_q [N];
  logic [3:0]    refrac_q [N];

  logic          tick;
  logic [VW-1:0] v_cur, v_leak, v_clamp, v_new;
  logic [VW:0]   v_sum;
  logic [3:0]    r_cur, r_new;
  logic          refractory, fire;

  assign tick = iENABLE && (presc_q == PRESC_MAX);

  always_comb begin
    presc_d = '0;
    if (iENABLE && !tick) presc_d = presc_q + PW'(1);
  end

  // Datapath for the neuron currently addressed by idx_q.
  always_comb begin
    v_cur      = v_q[idx_q];
    r_cur      = refrac_q[idx_q];
    refractory = (r_cur != 4'd0);
    v_leak     = v_cur - (v_cur >> LEAK_SHIFT);
    v_sum      = {1'b0, v_leak} + (rin_q[idx_q] ? WEIGHT_X : '0);
    v_clamp    = v_sum[VW] ? '1 : v_sum[VW-1:0];
    fire       = !refractory && (v_clamp >= THRESH_V);
    v_new      = v_clamp;
    r_new      = 4'd0;
    if (refractory) begin
      v_new = '0;
      r_new = r_cur - 4'd1;
    end else if (fire) begin
      v_new = '0;
      r_new = REFRAC_V;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rin_d    = rin_q;
    acc_d    = acc_q;
    spike_d  = spike_q;
    valid_d  = 1'b0;
    sat_d    = sat_q;
    missed_d = missed_q | (tick && (state_q != S_IDLE));
    case (state_q)
      S_IDLE: begin
        if (tick) begin
          rin_d   = iSPIKE_IN;
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_SWEEP;
        end
      end
      S_SWEEP: begin
        if (fire) acc_d[idx_q] = 1'b1;
        if (!refractory && v_sum[VW]) sat_d = 1'b1;
        if (idx_q == IDX_LAST) state_d = S_PUBLISH;
        else                   idx_d   = idx_q + IW'(1);
      end
      S_PUBLISH: begin
        spike_d = acc_q;
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Busy stays up through the strobe cycle so it spans the full N+2 cycle sweep.
    busy_d = (state_d != S_IDLE) || (state_q == S_PUBLISH);
  end

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      idx_q    <= '0;
      rin_q    <= '0;
      acc_q    <= '0;
      spike_q  <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      sat_q    <= 1'b0;
      missed_q <= 1'b0;
      for (int i = 0; i < N; i++) begin
        v_q[i]      <= '0;
        refrac_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      rin_q    <= rin_d;
      acc_q    <= acc_d;
      spike_q  <= spike_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      sat_q    <= sat_d;
      missed_q <= missed_d;
      if (state_q == S_SWEEP) begin
        v_q[idx_q]      <= v_new;
        refrac_q[idx_q] <= r_new;
      end
    end
  end

  assign oSPIKE       = spike_q;
  assign oSPIKE_VALID = valid_q;
  assign oBUSY        = busy_q;
  assign oSAT         = sat_q;
  assign oMISSED      = missed_q;
endmodule

// File: tb/tb_lif_neuron_core.sv
// Directed bench for lif_neuron_core: default bank, a saturating bank and an
// overrunning bank share clock and reset; each scenario task checks its own results.
module tb_lif_neuron_core;
  localparam int N   = 8;
  localparam int TD  = 120;
  localparam int TDS = 12;
  localparam int TDO = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic en_m, en_s, en_o;
  logic [N-1:0] spk_m, spk_s, spk_o;
  logic [N-1:0] spike_m, spike_s, spike_o;
  logic valid_m, busy_m, sat_m, missed_m;
  logic valid_s, busy_s, sat_s, missed_s;
  logic valid_o, busy_o, sat_o, missed_o;

  int checks = 0;
  int failures = 0;

  lif_neuron_core #(.N(N), .TICK_DIV(TD)) u_main (
    .iCLK(clk), .iRESETn(rst_n), .iENABLE(en_m), .iSPIKE_IN(spk_m),
    .oSPIKE(spike_m), .oSPIKE_VALID(valid_m), .oBUSY(busy_m), .oSAT(sat_m), .oMISSED(missed_m));

  lif_neuron_core #(.N(N), .WEIGHT(32768), .THRESH(65535), .TICK_DIV(TDS)) u_sat (
    .iCLK(clk), .iRESETn(rst_n), .iENABLE(en_s), .iSPIKE_IN(spk_s),
    .oSPIKE(spike_s), .oSPIKE_VALID(valid_s), .oBUSY(busy_s), .oSAT(sat_s), .oMISSED(missed_s));

  lif_neuron_core #(.N(N), .TICK_DIV(TDO)) u_ovr (
    .iCLK(clk), .iRESETn(rst_n), .iENABLE(en_o), .iSPIKE_IN(spk_o),
    .oSPIKE(spike_o), .oSPIKE_VALID(valid_o), .oBUSY(busy_o), .oSAT(sat_o), .oMISSED(missed_o));

  task automatic do_reset();
    rst_n = 1'b0;
    en_m = 1'b0; en_s = 1'b0; en_o = 1'b0;
    spk_m = '0; spk_s = '0; spk_o = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Returns the number of edges until a strobe is seen (sampled 1 ns after each edge).
  task automatic wait_valid(input int which, input int max_cyc, output bit ok, output int cyc);
    ok = 1'b0;
    cyc = 0;
    while (!ok && cyc < max_cyc) begin
      @(posedge clk); #1;
      cyc++;
      case (which)
        0:       ok = valid_m;
        1:       ok = valid_s;
        default: ok = valid_o;
      endcase
    end
  endtask

  task automatic test_reset();
    en_m = 1'b0; en_s = 1'b0; en_o = 1'b0;
    spk_m = '0; spk_s = '0; spk_o = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    checks++;
    if ({spike_m, valid_m, busy_m, sat_m, missed_m} !== '0) begin
      failures++; $display("FAIL reset_main: got %h expected 0", {spike_m, valid_m, busy_m, sat_m, missed_m});
    end
    checks++;
    if ({spike_s, valid_s, busy_s, sat_s, missed_s} !== '0) begin
      failures++; $display("FAIL reset_sat: got %h expected 0", {spike_s, valid_s, busy_s, sat_s, missed_s});
    end
    checks++;
    if ({spike_o, valid_o, busy_o, sat_o, missed_o} !== '0) begin
      failures++; $display("FAIL reset_ovr: got %h expected 0", {spike_o, valid_o, busy_o, sat_o, missed_o});
    end
    do_reset();
  endtask

  task automatic test_latency_enable();
    int cnt, first, vcnt, bcnt, cyc;
    bit ok, found;
    do_reset();
    spk_m = 8'hFF;
    cnt = 0;
    repeat (500) begin
      @(posedge clk); #1;
      if (valid_m || busy_m) cnt++;
    end
    checks++;
    if (cnt != 0) begin failures++; $display("FAIL disabled_idle: got %0d active cycles expected 0", cnt); end
    @(negedge clk);
    en_m = 1'b1;
    first = 0; vcnt = 0; bcnt = 0;
    for (int e = 1; e <= TD + N + 3; e++) begin
      @(posedge clk); #1;
      if (valid_m) begin vcnt++; if (first == 0) first = e; end
      if (busy_m) bcnt++;
    end
    $display("latency: first strobe at edge %0d, strobes %0d, busy cycles %0d", first, vcnt, bcnt);
    checks++;
    if (first != TD + N + 1) begin failures++; $display("FAIL first_strobe_latency: got %0d expected %0d", first, TD + N + 1); end
    checks++;
    if (vcnt != 1) begin failures++; $display("FAIL strobe_width: got %0d expected 1", vcnt); end
    checks++;
    if (bcnt != N + 2) begin failures++; $display("FAIL busy_width: got %0d expected %0d", bcnt, N + 2); end
    // Dropping enable mid-sweep must not abort the sweep in progress.
    found = 1'b0;
    for (int i = 0; i < 2 * TD && !found; i++) begin
      @(posedge clk); #1;
      found = busy_m;
    end
    @(negedge clk);
    en_m = 1'b0;
    wait_valid(0, N + 4, ok, cyc);
    checks++;
    if (!(found && ok)) begin failures++; $display("FAIL sweep_after_disable: got busy=%0d strobe=%0d expected 1 1", found, ok); end
    wait_valid(0, 2 * TD, ok, cyc);
    checks++;
    if (ok) begin failures++; $display("FAIL no_tick_when_disabled: got strobe after %0d cycles expected none", cyc); end
  endtask

  // Neuron 0 driven constantly with default parameters; timing counted from reset release.
  task automatic run_const(input string tag);
    int vtab [11] = '{1024, 1984, 2884, 3728, 4519, 5261, 5957, 6609, 7220, 7793, 0};
    int cyc, exp_cyc;
    bit ok;
    logic [N-1:0] exp_spk;
    for (int s = 1; s <= 24; s++) begin
      exp_cyc = (s == 1) ? TD + N + 1 : (s == 12) ? TD - 5 : TD;
      wait_valid(0, exp_cyc + 2, ok, cyc);
      exp_spk = (s == 11 || s == 24) ? 8'h01 : 8'h00;
      $display("%s strobe %0d: cycles=%0d spike=%h v0=%0d", tag, s, cyc, spike_m, u_main.v_q[0]);
      checks++;
      if (!ok || cyc != exp_cyc) begin
        failures++; $display("FAIL %s_timing[%0d]: got %0d cycles (seen=%0d) expected %0d", tag, s, cyc, ok, exp_cyc);
      end
      checks++;
      if (spike_m !== exp_spk) begin
        failures++; $display("FAIL %s_spike[%0d]: got %h expected %h", tag, s, spike_m, exp_spk);
      end
      if (s <= 11) begin
        checks++;
        if (int'(u_main.v_q[0]) != vtab[s-1]) begin
          failures++; $display("FAIL %s_v0[%0d]: got %0d expected %0d", tag, s, u_main.v_q[0], vtab[s-1]);
        end
      end
      if (s == 11) begin
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (spike_m !== 8'h01 || valid_m !== 1'b0) begin
          failures++; $display("FAIL %s_hold: got spike=%h valid=%b expected 01 0", tag, spike_m, valid_m);
        end
      end
    end
  endtask

  task automatic test_constant_drive();
    do_reset();
    spk_m = 8'h01;
    en_m = 1'b1;
    run_const("const");
  endtask

  task automatic test_reset_mid_sweep();
    int cyc;
    bit ok, found;
    do_reset();
    spk_m = 8'h01;
    en_m = 1'b1;
    ok = 1'b1;
    for (int s = 1; s <= 11 && ok; s++) wait_valid(0, TD + N + 2, ok, cyc);
    checks++;
    if (!ok || spike_m !== 8'h01) begin failures++; $display("FAIL pre_reset_spike: got %h expected 01", spike_m); end
    found = 1'b0;
    for (int i = 0; i < TD + 2 && !found; i++) begin
      @(posedge clk); #1;
      found = busy_m;
    end
    repeat (2) @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (!found || {spike_m, valid_m, busy_m, sat_m, missed_m} !== '0) begin
      failures++; $display("FAIL midsweep_outputs: got %h (busy seen=%0d) expected 0", {spike_m, valid_m, busy_m, sat_m, missed_m}, found);
    end
    checks++;
    if (u_main.v_q[0] !== '0 || u_main.refrac_q[0] !== '0) begin
      failures++; $display("FAIL midsweep_state: got v0=%0d refrac0=%0d expected 0 0", u_main.v_q[0], u_main.refrac_q[0]);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_const("rerun");
  endtask

  task automatic test_leak();
    int vtab [3] = '{1024, 1984, 2884};
    int cyc, prev, cur, timeouts;
    bit ok, spiked, nonmono;
    do_reset();
    spk_m = 8'h08;
    en_m = 1'b1;
    timeouts = 0; spiked = 1'b0; nonmono = 1'b0;
    for (int s = 1; s <= 3; s++) begin
      wait_valid(0, TD + N + 2, ok, cyc);
      if (!ok) timeouts++;
      if (spike_m !== '0) spiked = 1'b1;
      checks++;
      if (int'(u_main.v_q[3]) != vtab[s-1]) begin
        failures++; $display("FAIL leak_v3[%0d]: got %0d expected %0d", s, u_main.v_q[3], vtab[s-1]);
      end
    end
    spk_m = '0;
    prev = 2884;
    for (int s = 4; s <= 143; s++) begin
      wait_valid(0, TD + 2, ok, cyc);
      if (!ok) timeouts++;
      if (spike_m !== '0) spiked = 1'b1;
      cur = int'(u_main.v_q[3]);
      if (cur > prev || (prev >= 16 && cur == prev)) nonmono = 1'b1;
      prev = cur;
    end
    $display("leak: settled v3=%0d timeouts=%0d spiked=%0d nonmono=%0d", prev, timeouts, spiked, nonmono);
    checks++;
    if (timeouts != 0) begin failures++; $display("FAIL leak_strobes: got %0d timeouts expected 0", timeouts); end
    checks++;
    if (spiked) begin failures++; $display("FAIL leak_no_spike: got spike expected none"); end
    checks++;
    if (nonmono) begin failures++; $display("FAIL leak_monotonic: got non-decreasing step expected strict decay"); end
    checks++;
    if (prev != 15) begin failures++; $display("FAIL leak_settle: got %0d expected 15", prev); end
  endtask

  task automatic test_saturation();
    int cyc;
    bit ok;
    logic [N-1:0] exp_spk;
    logic exp_sat;
    do_reset();
    spk_s = 8'h01;
    en_s = 1'b1;
    for (int s = 1; s <= 4; s++) begin
      wait_valid(1, 3 * TDS, ok, cyc);
      exp_spk = (s == 3) ? 8'h01 : 8'h00;
      exp_sat = (s >= 3);
      $display("sat strobe %0d: spike=%h sat=%b v0=%0d", s, spike_s, sat_s, u_sat.v_q[0]);
      checks++;
      if (!ok || spike_s !== exp_spk) begin
        failures++; $display("FAIL sat_spike[%0d]: got %h (seen=%0d) expected %h", s, spike_s, ok, exp_spk);
      end
      checks++;
      if (sat_s !== exp_sat) begin failures++; $display("FAIL sat_flag[%0d]: got %b expected %b", s, sat_s, exp_sat); end
      if (s == 2) begin
        checks++;
        if (u_sat.v_q[0] !== 16'd63488) begin
          failures++; $display("FAIL sat_v0: got %0d expected 63488", u_sat.v_q[0]);
        end
      end
    end
  endtask

  task automatic test_overrun();
    int first, vcnt;
    do_reset();
    @(negedge clk);
    en_o = 1'b1;
    first = 0; vcnt = 0;
    for (int e = 1; e <= 120; e++) begin
      @(posedge clk); #1;
      if (e == 7) begin
        checks++;
        if (missed_o !== 1'b0) begin failures++; $display("FAIL missed_early: got %b expected 0", missed_o); end
      end
      if (e == 8) begin
        checks++;
        if (missed_o !== 1'b1) begin failures++; $display("FAIL missed_set: got %b expected 1", missed_o); end
      end
      if (valid_o) begin vcnt++; if (first == 0) first = e; end
    end
    $display("overrun: first strobe edge %0d, strobes %0d, missed=%b", first, vcnt, missed_o);
    checks++;
    if (first != 13) begin failures++; $display("FAIL ovr_first_strobe: got %0d expected 13", first); end
    checks++;
    if (vcnt != 9) begin failures++; $display("FAIL ovr_strobe_count: got %0d expected 9", vcnt); end
    checks++;
    if (missed_o !== 1'b1) begin failures++; $display("FAIL missed_sticky: got %b expected 1", missed_o); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency_enable();
    test_constant_drive();
    test_reset_mid_sweep();
    test_leak();
    test_saturation();
    test_overrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lif_neuron_core.md
# lif_neuron_core

Time-multiplexed bank of N leaky integrate-and-fire (LIF) neurons, instantiated inside the user design slot and clocked from the 120 MHz main PLL clock. A prescaler generates the network timestep. On each timestep the core samples an input spike vector and sweeps all neurons sequentially, one per clock. It then publishes a registered output spike vector with a one-cycle valid strobe for downstream routing logic or board pins.

## Interface
- N, 8: neuron count (2..64).
- VW, 16: membrane potential width, unsigned.
- WEIGHT, 1024: potential added per input spike.
- THRESH, 8192: firing threshold, 1..2^VW-1.
- LEAK_SHIFT, 4: leak is v>>LEAK_SHIFT per timestep.
- REFRAC, 2: refractory timesteps after a spike, 0..15.
- TICK_DIV, 120: clocks per timestep (1 µs at 120 MHz); must be ≥ 2.

- iCLK  in  1  sole clock, 120 MHz main clock.
- iRESETn  in  1  asynchronous active-low reset.
- iENABLE  in  1  runs the prescaler; low holds it at 0.
- iSPIKE_IN  in  N  input spike per neuron, sampled on tick.
- oSPIKE  out  N  output spikes of the last completed timestep.
- oSPIKE_VALID  out  1  one-cycle strobe: oSPIKE updated.
- oBUSY  out  1  high while a sweep is in progress (SWEEP or PUBLISH).
- oSAT  out  1  sticky: a membrane add saturated.
- oMISSED  out  1  sticky: a tick arrived while the core was not IDLE.

## Operation
- **Reset.**
  - Async reset clears all outputs, every membrane, every refractory counter, the prescaler, and the index.
  - State returns to IDLE.
- **Prescaler.**
  - Counts 0..TICK_DIV-1 while iENABLE is high.
  - Internal tick is high when the count equals TICK_DIV-1. The count then wraps to 0.
  - iENABLE low forces the count to 0 and suppresses the tick. A sweep already in progress still completes.
- **IDLE.**
  - On tick: latch iSPIKE_IN into rIN, clear the spike accumulator, set idx to 0, and go to SWEEP.
- **SWEEP.** One neuron idx is processed per clock:
  - If refrac[idx] is nonzero: decrement it. v stays 0 and the neuron does not spike.
  - Otherwise:
    - vl = v - (v>>LEAK_SHIFT).
    - vn = vl + (rIN[idx] ? WEIGHT : 0), computed at VW+1 bits.
    - If the carry bit is set, clamp vn to 2^VW-1 and set oSAT.
  - If vn ≥ THRESH: set acc[idx], set v to 0, set refrac[idx] to REFRAC. Otherwise v = vn.
  - After idx = N-1, go to PUBLISH.
- **PUBLISH.**
  - Load oSPIKE from acc and pulse oSPIKE_VALID for one cycle.
  - Go to IDLE.
- **Decided boundary behaviour.**
  - Potentials below 2^LEAK_SHIFT do not decay, because the shifted term is 0.
  - REFRAC=0 means the neuron integrates again on the next timestep.
  - A tick while not IDLE is dropped and sets oMISSED. The sweep in progress is unaffected.
  - oSAT and oMISSED clear only on reset.
- Membrane and refractory state live in N-entry register arrays indexed by idx.

## Timing
- Let edge k be the edge at which IDLE samples the tick. iSPIKE_IN is captured at edge k.
- Neuron i is written at edge k+1+i. The state enters PUBLISH at edge k+N.
- oSPIKE and oSPIKE_VALID take their new values at edge k+N+1. oSPIKE_VALID drops at edge k+N+2.
- oBUSY is high from edge k through edge k+N+1.
- oSPIKE holds its value between strobes.
- After iENABLE rises (prescaler at 0), the first tick is sampled TICK_DIV edges later.
- A sweep occupies N+2 cycles, so oMISSED never sets when TICK_DIV ≥ N+2.
- Reset asserted mid-sweep aborts immediately. No strobe is produced for that timestep.

## Test plan
- **Constant drive, defaults.** iSPIKE_IN[0]=1 held.
  - v sequence: 1024, 1984, 2884, ..., 7793, then 8330.
  - oSPIKE[0]=1 on the 11th strobe, 0 on strobes 12 and 13, and next 1 on strobe 24.
  - All other bits stay 0.
- **Leak.** Drive neuron 3 for 3 ticks, then 0.
  - No spike ever.
  - Membrane decays monotonically and settles at a value below 16.
- **Latency and enable.** Hold iENABLE low for 500 cycles: no strobe.
  - Raise iENABLE: first oSPIKE_VALID appears exactly TICK_DIV+N+1 cycles later.
  - It is one cycle wide, and oBUSY is high for N+2 cycles.
- **Saturation.** WEIGHT=32768, THRESH=65535, drive neuron 0.
  - Tick 3 sum is 92288, clamped to 65535.
  - oSAT=1 and oSPIKE[0]=1 on strobe 3; oSAT stays high.
- **Overrun.** TICK_DIV=4, N=8.
  - oMISSED sets on the first overlapped tick.
  - Strobes keep arriving every completed sweep.
- **Reset mid-sweep.** Drop iRESETn at edge k+3.
  - All outputs are 0 immediately.
  - After release, the constant-drive scenario reproduces the identical spike timing from scratch.
